wb_stream_writer_seq: RTL and testbench
=======================================

Name: wb_stream_writer_seq

Overview:
Descriptor sequencer for wb_stream_writer. Holds a small table of buffer descriptors (start address, buffer size, burst length), written by software through a Wishbone slave. A single-beat Wishbone master programs the writer's configuration port for each descriptor, enables the writer, waits for its irq, clears it, and advances. Sits between the CPU config bus and wb_stream_writer's wbs_* port; raises one irq after a whole descriptor list completes, or on error.

Parameters:
WB_AW, 32, Wishbone address width (both ports)
WB_DW, 32, Wishbone data width; fixed at 32
DESC_AW, 2, log2 of descriptor table depth (4 entries)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
wbs_adr_i  in  WB_AW  slave address; byte addressed
wbs_dat_i  in  WB_DW  slave write data
wbs_sel_i  in  4  byte selects; ignored, full-word access only
wbs_we_i  in  1  slave write enable
wbs_cyc_i  in  1  slave cycle
wbs_stb_i  in  1  slave strobe
wbs_dat_o  out  WB_DW  slave read data
wbs_ack_o  out  1  slave ack
wbs_err_o  out  1  tied 0
wbs_rty_o  out  1  tied 0
wbm_adr_o  out  WB_AW  master address to writer cfg port
wbm_dat_o  out  WB_DW  master write data
wbm_sel_o  out  4  constant 4'hf
wbm_we_o  out  1  constant 1 while cyc is asserted
wbm_cyc_o  out  1  master cycle
wbm_stb_o  out  1  master strobe
wbm_cti_o  out  3  constant 3'b111
wbm_bte_o  out  2  constant 2'b00
wbm_ack_i  in  1  ack from writer
wbm_err_i  in  1  error from writer
writer_irq_i  in  1  writer stream_m_irq_o, level
irq_o  out  1  list-done or error interrupt, level

Behaviour:
- Slave map (adr[7:0]):
  - 0x00 CTRL RW: bit0 run, bit1 loop. Writing 1 to bit2 clears done and err (self-clearing, reads 0).
  - 0x04 STATUS RO: bit0 busy, bit1 done, bit2 err, bits[8+:DESC_AW] current index.
  - 0x08 COUNT RW: descriptor count, DESC_AW+1 bits.
  - 0x40+16*i: descriptor i, word +0 start_addr, +4 buf_size, +8 burst_len.
  - Unmapped addresses read 0 and ignore writes.
- Slave timing: registered ack, one cycle after cyc&stb. Ack is never asserted two cycles in a row, so back-to-back accesses take 2 cycles each. Reads return data with ack.
- Reset values: all outputs 0 except constants. CTRL=0, COUNT=0, index=0, done=0, err=0, FSM=IDLE. Descriptor RAM contents are undefined after reset.
- Master: one single-beat write per state. cyc/stb rise in the state-entry cycle and hold until ack or err. The state advances the cycle after ack.
- FSM:
  - IDLE: on run=1 and COUNT!=0, go to W_ADDR (busy=1).
  - On run=1 and COUNT==0, set done and stay in IDLE (no master traffic).
  - W_ADDR: write start_addr[idx] to address 0x04.
  - W_SIZE: write buf_size[idx] to 0x08.
  - W_BURST: write burst_len[idx] to 0x0C.
  - W_EN: write 1 to 0x00.
  - WAIT_IRQ: stay until writer_irq_i==1.
  - W_CLR: write 2 to 0x00.
  - NEXT:
    - If idx==COUNT-1: on loop&run, set idx=0 and go to W_ADDR; otherwise set done=1, idx=0, and go to IDLE.
    - Else: idx+1, then go to W_ADDR if run, or IDLE if not.
- Descriptor fields are sampled in the state that writes them. Software may rewrite any descriptor while busy; the change takes effect on the next load of that entry.
- Clearing run mid-list: the current descriptor finishes through W_CLR, then NEXT returns to IDLE without setting done. idx is held, so setting run again resumes at that idx.
- wbm_err_i in any W_* state: drop cyc/stb, set err=1, go to IDLE, hold idx. Run is not cleared, but IDLE does not restart while err=1.
- irq_o = done | err, cleared only via CTRL bit2.
- Index arithmetic is modulo 2^DESC_AW. COUNT values above 2^DESC_AW saturate to 2^DESC_AW.
- Async reset mid-transaction: cyc/stb drop immediately.

Test Plan:
- Single descriptor (0x40, 64, 4), COUNT=1, run → master writes to adr 4,8,12,0 with data 0x40,64,4,1. After writer_irq_i: write 2 to adr 0, then done=1, irq_o=1, busy=0.
- COUNT=3 with distinct descriptors, writer model acks after 0-3 cycles → 15 master writes in order, idx sequence 0,1,2, one done at end. CTRL bit2 write clears irq_o.
- loop=1, COUNT=2, clear run during the 3rd descriptor (idx 0 again) → that descriptor completes through W_CLR, then IDLE with idx=1, done=0. Setting run again resumes at idx 1.
- wbm_err_i during W_SIZE of descriptor 1 → cyc drops the same cycle as err is seen, err=1, irq_o=1, idx=1, no further traffic until clear.
- COUNT=0, run=1 → no master cycles, done=1 within 2 clocks.
- rst low while WAIT_IRQ and during W_BURST → all outputs 0 asynchronously, FSM IDLE, CTRL/COUNT=0.

Source files
------------

// File: rtl/wb_stream_writer_seq.sv
// Descriptor sequencer for wb_stream_writer.
// Software loads up to 2**DESC_AW buffer descriptors through the slave port.
// The master port programs the writer's config registers for each entry,
// starts it, waits for its irq, clears it, and moves on.
module wb_stream_writer_seq #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int DESC_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WB_AW-1:0] wbs_adr_i,
  input  logic [WB_DW-1:0] wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic             wbs_we_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  output logic [WB_DW-1:0] wbs_dat_o,
  output logic             wbs_ack_o,
  output logic             wbs_err_o,
  output logic             wbs_rty_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic [2:0]       wbm_cti_o,
  output logic [1:0]       wbm_bte_o,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i,
  input  logic             writer_irq_i,
  output logic             irq_o
);

  localparam int DEPTH = 1 << DESC_AW;
  localparam int CW    = DESC_AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_W_ADDR, S_W_SIZE, S_W_BURST, S_W_EN, S_WAIT_IRQ, S_W_CLR, S_NEXT
  } state_t;

  state_t               state_reg, state_next;
  logic [DESC_AW-1:0]   idx_reg, idx_next;
  logic                 run_reg, loop_reg, done_reg, err_reg;
  logic                 done_set, err_set;
  logic [CW-1:0]        count_reg;
  logic                 ack_reg;
  logic [WB_DW-1:0]     rdata_reg, rdata_next;

  logic [WB_DW-1:0]     start_mem [DEPTH];
  logic [WB_DW-1:0]     size_mem  [DEPTH];
  logic [WB_DW-1:0]     burst_mem [DEPTH];

  // Slave address decode; only the low byte is significant.
  logic [7:0]           reg_adr, desc_off;
  logic [3:0]           desc_ent;
  logic [1:0]           desc_word;
  logic [DESC_AW-1:0]   desc_idx;
  logic                 desc_hit, slv_req, slv_wr, ctrl_clr, master_active, is_last;
  logic                 unused_ok;

  assign reg_adr   = wbs_adr_i[7:0];
  assign desc_off  = reg_adr - 8'h40;
  assign desc_ent  = desc_off[7:4];
  assign desc_word = desc_off[3:2];
  assign desc_idx  = desc_ent[DESC_AW-1:0];
  assign desc_hit  = (reg_adr >= 8'h40) && ({1'b0, desc_ent} < 5'(DEPTH)) && (desc_word != 2'd3);
  // Ack is registered and never back-to-back, so each access is taken once.
  assign slv_req   = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign slv_wr    = slv_req & wbs_we_i;
  assign ctrl_clr  = slv_wr && (reg_adr == 8'h00) && wbs_dat_i[2];
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[WB_AW-1:8], desc_off[1:0]};

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rdata_reg;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign irq_o     = done_reg | err_reg;

  // Slave read mux.
  always_comb begin
    rdata_next = '0;
    case (reg_adr)
      8'h00: begin
        rdata_next[0] = run_reg;
        rdata_next[1] = loop_reg;
      end
      8'h04: begin
        rdata_next[0]            = (state_reg != S_IDLE);
        rdata_next[1]            = done_reg;
        rdata_next[2]            = err_reg;
        rdata_next[8 +: DESC_AW] = idx_reg;
      end
      8'h08: rdata_next[CW-1:0] = count_reg;
      default: begin
        if (desc_hit) begin
          case (desc_word)
            2'd0:    rdata_next = start_mem[desc_idx];
            2'd1:    rdata_next = size_mem[desc_idx];
            default: rdata_next = burst_mem[desc_idx];
          endcase
        end
      end
    endcase
  end

  // Slave handshake and control/count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_reg   <= 1'b0;
      rdata_reg <= '0;
      run_reg   <= 1'b0;
      loop_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      ack_reg   <= slv_req;
      rdata_reg <= slv_req ? rdata_next : '0;
      if (slv_wr && reg_adr == 8'h00) begin
        run_reg  <= wbs_dat_i[0];
        loop_reg <= wbs_dat_i[1];
      end
      if (slv_wr && reg_adr == 8'h08)
        count_reg <= (wbs_dat_i > WB_DW'(DEPTH)) ? CW'(DEPTH) : wbs_dat_i[CW-1:0];
    end
  end

  // Descriptor table writes; contents are not reset.
  always_ff @(posedge clk) begin
    if (slv_wr && desc_hit) begin
      case (desc_word)
        2'd0:    start_mem[desc_idx] <= wbs_dat_i;
        2'd1:    size_mem[desc_idx]  <= wbs_dat_i;
        default: burst_mem[desc_idx] <= wbs_dat_i;
      endcase
    end
  end

  assign master_active = (state_reg == S_W_ADDR) || (state_reg == S_W_SIZE) ||
                         (state_reg == S_W_BURST) || (state_reg == S_W_EN) ||
                         (state_reg == S_W_CLR);
  assign is_last = ({1'b0, idx_reg} == (count_reg - CW'(1)));

  // Sequencer state register, index and sticky done/err flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= (done_reg & ~ctrl_clr) | done_set;
      err_reg   <= (err_reg & ~ctrl_clr) | err_set;
    end
  end

  // Next-state logic. IDLE will not start while done or err is pending, so a
  // finished list stays finished until software clears the interrupt.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (run_reg && !done_reg && !err_reg) begin
          if (count_reg != '0) state_next = S_W_ADDR;
          else                 done_set   = 1'b1;
        end
      end
      S_W_ADDR:   if (wbm_ack_i) state_next = S_W_SIZE;
      S_W_SIZE:   if (wbm_ack_i) state_next = S_W_BURST;
      S_W_BURST:  if (wbm_ack_i) state_next = S_W_EN;
      S_W_EN:     if (wbm_ack_i) state_next = S_WAIT_IRQ;
      S_WAIT_IRQ: if (writer_irq_i) state_next = S_W_CLR;
      S_W_CLR:    if (wbm_ack_i) state_next = S_NEXT;
      default: begin
        if (is_last) begin
          idx_next = '0;
          if (loop_reg && run_reg) begin
            state_next = S_W_ADDR;
          end else begin
            done_set   = 1'b1;
            state_next = S_IDLE;
          end
        end else begin
          idx_next   = idx_reg + DESC_AW'(1);
          state_next = run_reg ? S_W_ADDR : S_IDLE;
        end
      end
    endcase
    // A bus error aborts the list and keeps the index for inspection.
    if (master_active && wbm_err_i) begin
      state_next = S_IDLE;
      idx_next   = idx_reg;
      err_set    = 1'b1;
    end
  end

  // Master outputs; cyc drops in the same cycle an error is returned.
  always_comb begin
    wbm_cyc_o = master_active & ~wbm_err_i;
    wbm_stb_o = master_active & ~wbm_err_i;
    wbm_we_o  = master_active & ~wbm_err_i;
    wbm_sel_o = 4'hf;
    wbm_cti_o = 3'b111;
    wbm_bte_o = 2'b00;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    case (state_reg)
      S_W_ADDR: begin
        wbm_adr_o = WB_AW'(8'h04);
        wbm_dat_o = start_mem[idx_reg];
      end
      S_W_SIZE: begin
        wbm_adr_o = WB_AW'(8'h08);
        wbm_dat_o = size_mem[idx_reg];
      end
      S_W_BURST: begin
        wbm_adr_o = WB_AW'(8'h0C);
        wbm_dat_o = burst_mem[idx_reg];
      end
      S_W_EN:  wbm_dat_o = WB_DW'(1);
      S_W_CLR: wbm_dat_o = WB_DW'(2);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_stream_writer_seq.sv
// Bench for wb_stream_writer_seq: a writer model with variable ack latency,
// an expected-write queue built from the descriptor list, and directed
// scenarios for list completion, looping, run clear, errors and reset.
module tb_wb_stream_writer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = 4'hf;
  logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, writer_irq_i = 1'b0;
  logic        irq_o;

  wb_stream_writer_seq #(.WB_AW(32), .WB_DW(32), .DESC_AW(2)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_rty_o(wbs_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .writer_irq_i(writer_irq_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Software's view of the descriptor table and the expected master writes.
  logic [31:0] d_start [4];
  logic [31:0] d_size  [4];
  logic [31:0] d_burst [4];
  logic [31:0] exp_adr [$];
  logic [31:0] exp_dat [$];
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];

  function automatic void push_write(input logic [31:0] a, input logic [31:0] d);
    exp_adr.push_back(a);
    exp_dat.push_back(d);
  endfunction

  // One descriptor = program three fields, enable, then clear the irq.
  function automatic void push_desc(input int i);
    push_write(32'h04, d_start[i]);
    push_write(32'h08, d_size[i]);
    push_write(32'h0C, d_burst[i]);
    push_write(32'h00, 32'd1);
    push_write(32'h00, 32'd2);
  endfunction

  // Writer model: ack latency cycles through 0..3, optional injected error,
  // irq raised some cycles after enable and dropped when cleared.
  int          txn = 0;
  int          err_on_txn = -1;
  int          irq_dly = 3;
  int          irq_cnt = -1;
  int          wcnt = 0;
  logic [31:0] last_adr = '0, last_dat = '0;

  always @(negedge clk) begin
    if (!rst) begin
      wbm_ack_i    = 1'b0;
      wbm_err_i    = 1'b0;
      writer_irq_i = 1'b0;
      irq_cnt      = -1;
      wcnt         = 0;
    end else begin
      if (wbm_ack_i || wbm_err_i) begin
        if (wbm_ack_i && last_adr == 32'h0 && last_dat == 32'd1) irq_cnt = irq_dly;
        if (wbm_ack_i && last_adr == 32'h0 && last_dat == 32'd2) writer_irq_i = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wcnt      = 0;
        txn++;
      end
      if (irq_cnt > 0) irq_cnt--;
      else if (irq_cnt == 0) begin
        writer_irq_i = 1'b1;
        irq_cnt      = -1;
      end
      if (wbm_cyc_o && wbm_stb_o) begin
        if (wcnt >= txn % 4) begin
          if (txn == err_on_txn) wbm_err_i = 1'b1;
          else begin
            wbm_ack_i = 1'b1;
            last_adr  = wbm_adr_o;
            last_dat  = wbm_dat_o;
          end
        end else wcnt++;
      end
    end
  end

  // Compare process: every master cycle must be expected, every acked write
  // must match the head of the expected queue.
  always @(negedge clk) begin
    #2;
    if (wbm_cyc_o) begin
      check("cyc_expected", 32'(exp_adr.size() != 0), 32'd1);
      check("wbm_const", {22'd0, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o},
            {22'd0, 1'b1, 4'hf, 3'b111, 2'b00});
      if (wbm_ack_i) begin
        log_adr.push_back(wbm_adr_o);
        log_dat.push_back(wbm_dat_o);
        if (exp_adr.size() != 0) begin
          check("wbm_adr", wbm_adr_o, exp_adr[0]);
          check("wbm_dat", wbm_dat_o, exp_dat[0]);
          void'(exp_adr.pop_front());
          void'(exp_dat.pop_front());
        end
      end
    end
    if (wbm_err_i) check("cyc_drop_on_err", 32'(wbm_cyc_o), 32'd0);
  end

  task automatic wb_access(input logic [31:0] adr, input logic [31:0] dat,
                           input logic we, output logic [31:0] rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_we_i = we;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wbs_ack_o && n < 8);
    check("slave_ack_latency", n, 1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wb_access(adr, dat, 1'b1, rd);
    $display("slave write adr=%h dat=%h", adr, dat);
  endtask

  task automatic wb_read_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_access(adr, 32'd0, 1'b0, rd);
    $display("slave read  adr=%h dat=%h", adr, rd);
    check(name, rd, exp);
  endtask

  task automatic set_desc(input int i, input logic [31:0] s, input logic [31:0] z, input logic [31:0] b);
    d_start[i] = s; d_size[i] = z; d_burst[i] = b;
    wb_write(32'h40 + 32'(16 * i), s);
    wb_write(32'h44 + 32'(16 * i), z);
    wb_write(32'h48 + 32'(16 * i), b);
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n;
    n = 0;
    while (!irq_o && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(irq_o), 32'd1);
  endtask

  task automatic wait_log(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (log_adr.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(log_adr.size() >= target), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n0;
    int polls;
    logic [31:0] st;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_mdat", wbm_adr_o | wbm_dat_o | wbs_dat_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    check("err_rty_tied", {30'd0, wbs_err_o, wbs_rty_o}, 32'd0);
    wb_read_check("rst_ctrl", 32'h00, 32'h0);
    wb_read_check("rst_status", 32'h04, 32'h0);
    wb_read_check("rst_count", 32'h08, 32'h0);

    // Single descriptor.
    set_desc(0, 32'h40, 32'd64, 32'd4);
    wb_write(32'h08, 32'd1);
    base = log_adr.size();
    push_desc(0);
    wb_write(32'h00, 32'd1);
    wait_irq("t1_irq", 400);
    check("t1_drained", exp_adr.size(), 0);
    check("t1_lit_adr0", log_adr[base], 32'h04);
    check("t1_lit_dat0", log_dat[base], 32'h40);
    check("t1_lit_dat1", log_dat[base + 1], 32'd64);
    check("t1_lit_adr2", log_adr[base + 2], 32'h0C);
    check("t1_lit_dat3", log_dat[base + 3], 32'd1);
    check("t1_lit_dat4", log_dat[base + 4], 32'd2);
    wb_read_check("t1_status_done", 32'h04, 32'h002);
    wb_write(32'h00, 32'd4);
    check("t1_irq_cleared", 32'(irq_o), 32'd0);
    wb_read_check("t1_ctrl_bit2_reads0", 32'h00, 32'h0);
    wb_read_check("unmapped_4c", 32'h4C, 32'h0);
    wb_read_check("unmapped_10", 32'h10, 32'h0);

    // Three descriptors, count saturation.
    set_desc(0, 32'h1000, 32'd256, 32'd8);
    set_desc(1, 32'h2000, 32'd128, 32'd16);
    set_desc(2, 32'h3000, 32'd512, 32'd2);
    wb_write(32'h08, 32'd7);
    wb_read_check("count_saturate", 32'h08, 32'd4);
    wb_write(32'h08, 32'd3);
    base = log_adr.size();
    push_desc(0); push_desc(1); push_desc(2);
    wb_write(32'h00, 32'd1);
    wait_irq("t2_irq", 600);
    check("t2_write_count", log_adr.size() - base, 15);
    check("t2_drained", exp_adr.size(), 0);
    wb_read_check("t2_status_done", 32'h04, 32'h002);
    wb_write(32'h00, 32'd4);
    check("t2_irq_cleared", 32'(irq_o), 32'd0);
    wb_read_check("t2_status_clear", 32'h04, 32'h000);

    // Loop with run cleared during the third descriptor.
    wb_write(32'h08, 32'd2);
    base = log_adr.size();
    push_desc(0); push_desc(1); push_desc(0);
    wb_write(32'h00, 32'd3);
    wait_log("t3_third_started", base + 11, 600);
    wb_write(32'h00, 32'd2);
    polls = 0;
    st = 32'h1;
    while (st[0] && polls < 40) begin
      wb_access(32'h04, 32'd0, 1'b0, st);
      polls++;
    end
    check("t3_status_paused", st, 32'h100);
    check("t3_drained", exp_adr.size(), 0);
    check("t3_no_irq", 32'(irq_o), 32'd0);
    push_desc(1);
    wb_write(32'h00, 32'd1);
    wait_irq("t3_resume_irq", 400);
    check("t3_resume_drained", exp_adr.size(), 0);
    wb_read_check("t3_status_done", 32'h04, 32'h002);
    wb_write(32'h00, 32'd4);

    // Bus error during W_SIZE of descriptor 1.
    wb_write(32'h08, 32'd3);
    err_on_txn = txn + 6;
    push_desc(0);
    push_write(32'h04, d_start[1]);
    push_write(32'h08, d_size[1]);
    wb_write(32'h00, 32'd1);
    wait_irq("t4_irq", 400);
    check("t4_err_write_pending", exp_adr.size(), 1);
    exp_adr.delete(); exp_dat.delete();
    wb_read_check("t4_status_err", 32'h04, 32'h104);
    n0 = log_adr.size();
    repeat (20) @(posedge clk);
    #1;
    check("t4_no_traffic", log_adr.size(), n0);
    err_on_txn = -1;
    wb_write(32'h00, 32'd4);
    check("t4_irq_cleared", 32'(irq_o), 32'd0);
    wb_read_check("t4_status_clear", 32'h04, 32'h100);

    // Empty list.
    n0 = log_adr.size();
    wb_write(32'h08, 32'd0);
    wb_write(32'h00, 32'd1);
    wait_irq("t5_done_fast", 2);
    check("t5_no_traffic", log_adr.size(), n0);
    wb_read_check("t5_status", 32'h04, 32'h102);
    wb_write(32'h00, 32'd4);

    // Reset while waiting for the writer irq (idx 1 is last with COUNT=2).
    wb_write(32'h08, 32'd2);
    irq_dly = 12;
    base = log_adr.size();
    push_desc(1);
    wb_write(32'h00, 32'd1);
    wait_log("t6_en_written", base + 4, 200);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6a_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t6a_irq_ack", {30'd0, irq_o, wbs_ack_o}, 32'd0);
    exp_adr.delete(); exp_dat.delete();
    irq_dly = 3;
    @(negedge clk); @(negedge clk) rst = 1'b1;
    wb_read_check("t6a_ctrl", 32'h00, 32'h0);
    wb_read_check("t6a_count", 32'h08, 32'h0);
    wb_read_check("t6a_status", 32'h04, 32'h0);

    // Reset during W_BURST.
    set_desc(0, 32'h5000, 32'd32, 32'd1);
    wb_write(32'h08, 32'd1);
    base = log_adr.size();
    push_desc(0);
    wb_write(32'h00, 32'd1);
    wait_log("t6_size_written", base + 2, 200);
    check("t6b_in_burst", wbm_adr_o, 32'h0C);
    rst = 1'b0;
    #1;
    check("t6b_cyc", 32'(wbm_cyc_o), 32'd0);
    check("t6b_adr_dat", wbm_adr_o | wbm_dat_o, 32'd0);
    exp_adr.delete(); exp_dat.delete();
    @(negedge clk); @(negedge clk) rst = 1'b1;
    wb_read_check("t6b_ctrl", 32'h00, 32'h0);
    wb_read_check("t6b_count", 32'h08, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("t6b_idle_after", 32'(wbm_cyc_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
